radix_2_div: RTL and testbench

- Iterative restoring divider for the RV32M DIV/DIVU/REM/REMU operations, executed in the idex stage.
- Shares the start-pulse / one-cycle-finish handshake of the multi-cycle multiplier, so the stall logic treats both units identically.
- Computes the quotient and remainder together, one bit per cycle, on operand magnitudes, then applies a sign fix-up.
- Divide-by-zero and signed overflow are detected at start and complete early.

---
 rtl/radix_2_div_pkg.sv | 32 +++
 rtl/radix_2_div.sv | 138 +++++++++++++
 tb/tb_radix_2_div.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/radix_2_div_pkg.sv
// Shared idex definitions for the iterative divider: FSM encoding,
// RV M-extension result constants and a conditional-negate helper.
package radix_2_div_pkg;

  // Widest operand the helpers below can handle.
  localparam int unsigned MAX_DW = 64;

  // Divider control states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    FIX    = 2'd2,
    FINISH = 2'd3
  } div_state_t;

  // Quotient returned on divide-by-zero: all ones in the low dw bits.
  function automatic logic [MAX_DW-1:0] div_zero_q(input int unsigned dw);
    return (MAX_DW'(1) << dw) - MAX_DW'(1);
  endfunction

  // Most negative two's-complement value of width dw (1 followed by zeros).
  function automatic logic [MAX_DW-1:0] signed_min(input int unsigned dw);
    return MAX_DW'(1) << (dw - 1);
  endfunction

  // Two's-complement negate when neg is set; doubles as |x| for sign-tagged x.
  function automatic logic [MAX_DW-1:0] cond_neg(input logic [MAX_DW-1:0] x,
                                                 input logic              neg);
    return neg ? (~x + MAX_DW'(1)) : x;
  endfunction

endpackage

// File: rtl/radix_2_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU. One quotient bit per
// cycle on operand magnitudes, then a sign fix-up. Divide-by-zero and
// signed overflow are resolved at start and finish on the next cycle.
// DW must be even, at least 4 and no wider than MAX_DW.
module radix_2_div
  import radix_2_div_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          signed_op,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_finish,
  output logic          busy
);

  localparam logic [DW-1:0] DZQ  = DW'(div_zero_q(DW));
  localparam logic [DW-1:0] SMIN = DW'(signed_min(DW));

  div_state_t    state, state_nxt;
  logic [DW-1:0] dvd, dvs, q;
  logic [DW:0]   rem;
  logic [CW-1:0] cnt;
  logic          q_neg, r_neg;

  logic          div_zero, sgn_ovf, a_neg, b_neg;
  logic [DW-1:0] dvd_mag, dvs_mag, q_fix, r_fix;
  logic [DW+1:0] rem_sh, diff;

  // Operand classification, magnitudes, one restoring step and sign fix-up.
  // rem[DW] is always zero, so {rem, bit} equals the zero-extended
  // {rem[DW-1:0], bit} and the subtraction borrow lands in diff[DW+1].
  always_comb begin
    div_zero = (divisor == '0);
    sgn_ovf  = signed_op && (dividend == SMIN) && (divisor == '1);
    a_neg    = signed_op & dividend[DW-1];
    b_neg    = signed_op & divisor[DW-1];
    dvd_mag  = DW'(cond_neg(MAX_DW'(dividend), a_neg));
    dvs_mag  = DW'(cond_neg(MAX_DW'(divisor), b_neg));
    rem_sh   = {rem, dvd[DW-1]};
    diff     = rem_sh - {2'b00, dvs};
    q_fix    = DW'(cond_neg(MAX_DW'(q), q_neg));
    r_fix    = DW'(cond_neg(MAX_DW'(rem[DW-1:0]), r_neg));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic plus the busy/finish handshake decoded from state.
  always_comb begin
    state_nxt  = state;
    div_finish = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (div_zero || sgn_ovf) ? FINISH : DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (cnt == CW'(DW - 1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = FINISH;
      end
      FINISH: begin
        div_finish = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift/subtract iterations and result registers.
  // Results are only written at start (special cases) or in FIX, so they
  // hold through IDLE until the next accepted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd       <= '0;
      dvs       <= '0;
      q         <= '0;
      rem       <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              quotient  <= DZQ;
              remainder <= dividend;
            end else if (sgn_ovf) begin
              quotient  <= dividend;
              remainder <= '0;
            end else begin
              dvd   <= dvd_mag;
              dvs   <= dvs_mag;
              q     <= '0;
              rem   <= '0;
              cnt   <= '0;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
            end
          end
        end
        DIV: begin
          dvd <= {dvd[DW-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (!diff[DW+1]) begin
            rem <= diff[DW:0];
            q   <= {q[DW-2:0], 1'b1};
          end else begin
            rem <= rem_sh[DW:0];
            q   <= {q[DW-2:0], 1'b0};
          end
        end
        FIX: begin
          quotient  <= q_fix;
          remainder <= r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_radix_2_div.sv
// Self-checking bench for radix_2_div: an arithmetic reference model predicts
// results and finish timing, and a single compare process checks the DUT
// outputs every cycle against it.
module tb_radix_2_div;

  localparam int DW = 32;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          signed_op;
  logic [DW-1:0] dividend, divisor;
  logic [DW-1:0] quotient, remainder;
  logic          div_finish, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model of the operation in flight and of the held result registers.
  logic          pending = 1'b0;
  logic          normal  = 1'b0;
  int            issue_cyc = 0;
  int            exp_lat   = 0;
  logic [DW-1:0] exp_q = '0, exp_r = '0;
  logic [DW-1:0] hold_q = '0, hold_r = '0;

  radix_2_div #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_finish (div_finish),
    .busy       (busy)
  );

  // 10-unit clock and a free-running cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference RV32M semantics using plain arithmetic.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == SMIN && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one operation (called at posedge+1) and record what the model expects.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mq, mr;
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    ref_div(s, a, b, mq, mr);
    exp_q     = mq;
    exp_r     = mr;
    normal    = !(b == 32'd0 || (s && a == SMIN && b == 32'hFFFF_FFFF));
    exp_lat   = normal ? DW + 2 : 1;
    issue_cyc = cyc;
    pending   = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = ~s;
  endtask

  // Bounded wait for the model to see the finish; returns at posedge+1.
  task automatic waitDone();
    int n = 0;
    while (pending && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (pending) begin
      checkOutput("finish_timeout", 64'd1, 64'd0);
      pending = 1'b0;
    end
  endtask

  task automatic stepTo(input int target);
    for (int i = 0; i < 200 && cyc < target; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Compare process: checks every output every cycle on the falling edge.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      checkOutput("rst_quotient", quotient, 0);
      checkOutput("rst_remainder", remainder, 0);
      checkOutput("rst_finish", div_finish, 0);
      checkOutput("rst_busy", busy, 0);
    end else if (pending && cyc == issue_cyc + exp_lat) begin
      checkOutput("finish_pulse", div_finish, 1);
      checkOutput("finish_busy", busy, 0);
      checkOutput("quotient", quotient, exp_q);
      checkOutput("remainder", remainder, exp_r);
      hold_q  = exp_q;
      hold_r  = exp_r;
      pending = 1'b0;
    end else begin
      checkOutput("no_finish", div_finish, 0);
      checkOutput("busy", busy,
                  (pending && normal && cyc > issue_cyc && cyc <= issue_cyc + DW + 1) ? 1 : 0);
      checkOutput("hold_quotient", quotient, hold_q);
      checkOutput("hold_remainder", remainder, hold_r);
    end
  end

  initial begin
    logic [31:0] mq, mr, a, b;
    logic s;
    int t;

    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;

    // Hand-computed pins on the reference model itself.
    ref_div(1'b0, 32'd20, 32'd3, mq, mr);
    checkOutput("model_u20_3_q", mq, 32'd6);
    checkOutput("model_u20_3_r", mr, 32'd2);
    ref_div(1'b1, 32'hFFFF_FFF9, 32'd2, mq, mr);
    checkOutput("model_sm7_2_q", mq, 32'hFFFF_FFFD);
    checkOutput("model_sm7_2_r", mr, 32'hFFFF_FFFF);
    ref_div(1'b1, 32'd7, 32'hFFFF_FFFE, mq, mr);
    checkOutput("model_s7_m2_q", mq, 32'hFFFF_FFFD);
    checkOutput("model_s7_m2_r", mr, 32'd1);
    ref_div(1'b1, SMIN, 32'd2, mq, mr);
    checkOutput("model_smin_2_q", mq, 32'hC000_0000);
    ref_div(1'b0, SMIN, 32'hFFFF_FFFF, mq, mr);
    checkOutput("model_u_ovf_r", mr, 32'h8000_0000);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    applyStimulus(1'b0, 32'd20, 32'd3);          waitDone();
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);   waitDone();
    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);   waitDone();
    applyStimulus(1'b1, 32'h0000_1234, 32'd0);   waitDone();
    applyStimulus(1'b0, 32'h0000_1234, 32'd0);   waitDone();
    applyStimulus(1'b1, SMIN, 32'hFFFF_FFFF);    waitDone();
    applyStimulus(1'b0, SMIN, 32'hFFFF_FFFF);    waitDone();
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);   waitDone();
    applyStimulus(1'b1, SMIN, 32'd2);            waitDone();
    applyStimulus(1'b1, 32'd0, 32'd5);           waitDone();

    // A second start mid-operation is ignored.
    applyStimulus(1'b0, 32'd20, 32'd3);
    t = issue_cyc;
    stepTo(t + 5);
    signed_op = 1'b1; dividend = 32'd999; divisor = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();

    // A start during the FINISH cycle is ignored too.
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7);
    t = issue_cyc;
    stepTo(t + DW + 2);
    signed_op = 1'b0; dividend = 32'd50; divisor = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone();
    repeat (DW + 5) begin @(posedge clk); #1; end

    // Reset mid-operation aborts without a finish pulse.
    applyStimulus(1'b0, 32'd1000, 32'd7);
    t = issue_cyc;
    stepTo(t + 10);
    rst_n   = 1'b0;
    pending = 1'b0;
    hold_q  = '0;
    hold_r  = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (DW + 5) begin @(posedge clk); #1; end
    applyStimulus(1'b0, 32'd1000, 32'd7);        waitDone();

    // Random pairs, back to back, biased towards corner cases.
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 11))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: begin a = SMIN; b = 32'hFFFF_FFFF; end
        3: a = SMIN;
        4: a = 32'd0;
        default: ;
      endcase
      applyStimulus(s, a, b);
      waitDone();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
